// File: rtl/npc_pkg.sv
// NPC core shared definitions: widths, reset vector, NOP encoding and
// the instruction fetch FSM state encoding.
package npc_pkg;

   localparam int          XLEN         = 32;
   localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
   localparam logic [31:0] INST_NOP     = 32'h0000_0013;

   typedef enum logic [2:0] {
      IFU_IDLE  = 3'd0,
      IFU_REQ   = 3'd1,
      IFU_WAIT  = 3'd2,
      IFU_DRAIN = 3'd3,
      IFU_HOLD  = 3'd4
   } ifu_state_t;

endpackage

// File: rtl/ifu_out_buf.sv
// Fetch output buffer: instruction word, its PC and fault flag,
// loaded together when the fetch FSM captures a result.
module ifu_out_buf #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ld,
   input  logic [XLEN-1:0] d_inst,
   input  logic [XLEN-1:0] d_pc,
   input  logic            d_err,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   output logic            inst_err
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst     <= '0;
         inst_pc  <= '0;
         inst_err <= 1'b0;
      end else if (ld) begin
         inst     <= d_inst;
         inst_pc  <= d_pc;
         inst_err <= d_err;
      end
   end

endmodule

// File: rtl/ifu_fetch.sv
// NPC instruction fetch unit: single-outstanding memory read, buffered
// hand-off to decode. Optional macro: IFU_MISALIGN_CHECK_EN.
module ifu_fetch #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc,
   input  logic            pc_valid,
   input  logic            flush,
   output logic            pc_adv,
   output logic            req_valid,
   output logic [XLEN-1:0] req_addr,
   input  logic            req_ready,
   input  logic            resp_valid,
   input  logic [XLEN-1:0] resp_data,
   input  logic            resp_err,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   output logic            inst_err,
   input  logic            inst_ready
);

   import npc_pkg::*;

   ifu_state_t      state_q;
   ifu_state_t      state_d;
   logic [XLEN-1:0] addr_q;
   logic            addr_ld;
   logic            misal;
   logic            buf_ld;
   logic [XLEN-1:0] buf_inst;
   logic [XLEN-1:0] buf_pc;
   logic            buf_err;

`ifdef IFU_MISALIGN_CHECK_EN
   assign misal = (pc[1:0] != 2'b00);
`else
   assign misal = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IFU_IDLE;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         if (addr_ld) addr_q <= pc;
      end
   end

   // Flush is tested first in every state so it beats any handshake.
   always_comb begin
      state_d  = state_q;
      addr_ld  = 1'b0;
      buf_ld   = 1'b0;
      buf_inst = resp_data;
      buf_pc   = addr_q;
      buf_err  = resp_err;
      unique case (state_q)
         IFU_IDLE: begin
            if (pc_valid && !flush) begin
               if (misal) begin
                  buf_ld   = 1'b1;
                  buf_inst = XLEN'(INST_NOP);
                  buf_pc   = pc;
                  buf_err  = 1'b1;
                  state_d  = IFU_HOLD;
               end else begin
                  addr_ld = 1'b1;
                  state_d = IFU_REQ;
               end
            end
         end
         IFU_REQ: begin
            if (flush)
               state_d = req_ready ? IFU_DRAIN : IFU_IDLE;
            else if (req_ready)
               state_d = IFU_WAIT;
         end
         IFU_WAIT: begin
            if (flush) begin
               state_d = resp_valid ? IFU_IDLE : IFU_DRAIN;
            end else if (resp_valid) begin
               buf_ld  = 1'b1;
               state_d = IFU_HOLD;
            end
         end
         IFU_DRAIN: begin
            if (resp_valid) state_d = IFU_IDLE;
         end
         IFU_HOLD: begin
            if (flush || inst_ready) state_d = IFU_IDLE;
         end
         default: state_d = IFU_IDLE;
      endcase
   end

   assign req_valid  = (state_q == IFU_REQ);
   assign req_addr   = {addr_q[XLEN-1:2], 2'b00};
   assign inst_valid = (state_q == IFU_HOLD);
   assign pc_adv     = inst_valid & inst_ready & ~flush;

   ifu_out_buf #(
      .XLEN (XLEN)
   ) u_buf (
      .clk      (clk),
      .rst      (rst),
      .ld       (buf_ld),
      .d_inst   (buf_inst),
      .d_pc     (buf_pc),
      .d_err    (buf_err),
      .inst     (inst),
      .inst_pc  (inst_pc),
      .inst_err (inst_err)
   );

endmodule
